object_spawner: RTL and testbench
=================================

# object_spawner

Frame-level scheduler for the object bank. Once per frame it scans slots 1..N-1 through a bank read port, retires falling objects that have left the screen, and periodically writes a new falling object into the lowest free slot with a pseudo-random horizontal position and bitmap. Slot 0 (player) is never read-modified or written. It sits between the VGA timing generator (frame tick) and the object bank's write port.

## Interface
- OBJECT_BANK_SIZE, 16: number of bank slots, including player slot 0
- IDX_W, 4: slot index width, clog2(OBJECT_BANK_SIZE)
- SCREEN_W, 800: visible width in pixels
- SCREEN_H, 600: visible height in lines
- OBJ_SIZE, 32: width and height of spawned objects
- SPAWN_PERIOD, 60: accepted frame ticks between spawn attempts (≥1)
- LFSR_SEED, 16'hACE1: LFSR reset value (non-zero)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (bank update point)
- enable  in  1  game running; when low, frame ticks are ignored
- clear  in  1  one-cycle pulse: remove every falling object
- rd_idx  out  IDX_W  bank read address
- rd_data  in  35  bank record at rd_idx, combinational, same cycle
- wr_en  out  1  bank write strobe
- wr_idx  out  IDX_W  bank write address
- wr_data  out  35  record to write: Height[34:29] Width[28:23] Bitmap[22:21] Exists[20] PosV[19:10] PosH[9:0]
- busy  out  1  FSM not in IDLE
- spawned  out  1  one-cycle pulse: new object written
- dropped  out  1  one-cycle pulse: spawn due but no free slot
- active_count  out  IDX_W  existing objects in slots 1..N-1

## Operation
- States: IDLE, SCAN, SPAWN, CLEAR.
- IDLE: if clear → CLEAR (priority over tick). Else if frame_tick & enable → tick accepted, SCAN with slot=1.
- Accepted tick: LFSR steps once (16-bit Fibonacci, taps 16,14,13,11); frame_cnt increments; if frame_cnt == SPAWN_PERIOD-1 it wraps to 0 and spawn_pending sets.
- SCAN: rd_idx=slot. If Exists=1 and PosV ≥ SCREEN_H → wr_en=1, wr_idx=slot, wr_data=rd_data with Exists=0 (retire). Slot counts as free if Exists=0 or retired this cycle; the lowest free slot is latched as free_idx. Surviving objects counted. After slot N-1 → SPAWN.
- SPAWN: if spawn_pending and free slot found → write {OBJ_SIZE, OBJ_SIZE, bmp, 1, 10'd0, h} to free_idx, spawned=1. If pending and none free → dropped=1. spawn_pending clears either way. active_count ← survivors + spawned. → IDLE.
- h = lfsr[9:0] if < SCREEN_W-OBJ_SIZE, else lfsr[9:0] − (SCREEN_W−OBJ_SIZE). bmp = lfsr[11:10], with 2'b11 (player bitmap) replaced by 2'b00.
- CLEAR: slots 1..N-1 in order, one per cycle, written with rd_data and Exists=0. After N-1: active_count=0, spawn_pending=0, frame_cnt=0 → IDLE. LFSR is not reset.
- frame_tick or clear while busy: ignored (no counter or LFSR change).
- enable low: ticks ignored. A scan in progress completes.

## Timing
- Reset (async): state IDLE, wr_en=0, rd_idx=0, wr_idx=0, wr_data=0, busy=0, spawned=0, dropped=0, active_count=0, frame_cnt=0, spawn_pending=0, lfsr=LFSR_SEED.
- Tick sampled at edge k → SCAN occupies cycles k+1..k+N-1, SPAWN at k+N, IDLE at k+N+1. Total N cycles busy (16 by default).
- Writes are combinational from state/rd_data and committed by the bank on the same edge. At most one write per cycle.
- spawned/dropped are registered or combinational but high only during the SPAWN cycle. active_count changes only on leaving SPAWN or CLEAR.
- rst asserted mid-scan or mid-clear aborts immediately. No write is issued after rst rises.

## Test plan
- Reset, bank with slots 1–2 existing at PosV 100/200, SPAWN_PERIOD=1 → 1 tick: no retires, spawn to slot 3 with PosV=0, Width=Height=32, Exists=1; active_count=3; busy high exactly 16 cycles.
- Slot 2 at PosV=600, slot 1 at 599 → tick: slot 2 written Exists=0, slot 1 untouched; with spawn due, new object lands in slot 2.
- All slots 1..15 existing below 600, spawn due → dropped pulse, no write, active_count=15.
- SPAWN_PERIOD=60 → 59 ticks produce no spawn; 60th spawns. Ticks with enable=0 and ticks during busy do not advance the count.
- clear during IDLE → 15 consecutive writes to slots 1..15 with Exists=0, slot 0 never addressed, active_count=0. clear asserted together with frame_tick → CLEAR wins.
- Sweep 1000 spawns: every PosH ≤ 767, bitmap never 2'b11, sequence matches LFSR model from seed 16'hACE1. rst mid-SCAN → all outputs at reset values the same cycle.

Source files
------------

// File: rtl/object_spawner_if.sv
// Signal bundle between the object spawner, the VGA frame tick source and the object bank.
// The master side is the spawner; the slave side is the bank/timing environment.
interface object_spawner_if #(
  parameter int unsigned IDX_W = 4
);
  logic             frame_tick;
  logic             enable;
  logic             clear;
  logic [IDX_W-1:0] rd_idx;
  logic [34:0]      rd_data;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [34:0]      wr_data;
  logic             busy;
  logic             spawned;
  logic             dropped;
  logic [IDX_W-1:0] active_count;

  modport master (
    input  frame_tick, enable, clear, rd_data,
    output rd_idx, wr_en, wr_idx, wr_data, busy, spawned, dropped, active_count
  );

  modport slave (
    output frame_tick, enable, clear, rd_data,
    input  rd_idx, wr_en, wr_idx, wr_data, busy, spawned, dropped, active_count
  );
endinterface

// File: rtl/object_spawner.sv
// Per-frame object bank scheduler: scans slots 1..N-1, retires off-screen objects and
// periodically spawns a new falling object into the lowest free slot.
module object_spawner #(
  parameter int unsigned OBJECT_BANK_SIZE = 16,
  parameter int unsigned IDX_W            = 4,
  parameter int unsigned SCREEN_W         = 800,
  parameter int unsigned SCREEN_H         = 600,
  parameter int unsigned OBJ_SIZE         = 32,
  parameter int unsigned SPAWN_PERIOD     = 60,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input logic              clk,
  input logic              rst,
  object_spawner_if.master bus
);
  localparam int unsigned     FcW       = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [IDX_W-1:0] LastSlot = IDX_W'(OBJECT_BANK_SIZE - 1);
  localparam logic [IDX_W-1:0] FirstSlot = IDX_W'(1);
  localparam logic [9:0]      HRange    = 10'(SCREEN_W - OBJ_SIZE);
  localparam logic [9:0]      ScreenH   = 10'(SCREEN_H);
  localparam logic [5:0]      ObjSz     = 6'(OBJ_SIZE);
  localparam logic [FcW-1:0]  FrameLast = FcW'(SPAWN_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StScan, StSpawn, StClear} state_e;

  state_e           r_state, w_state_next;
  logic [IDX_W-1:0] r_slot, w_slot_next;
  logic [IDX_W-1:0] r_free_idx, w_free_idx_next;
  logic             r_free_found, w_free_found_next;
  logic [IDX_W-1:0] r_survivors, w_survivors_next;
  logic [IDX_W-1:0] r_active, w_active_next;
  logic             r_pending, w_pending_next;
  logic [FcW-1:0]   r_frame_cnt, w_frame_cnt_next;
  logic [15:0]      r_lfsr, w_lfsr_next;

  logic             w_exists, w_retire, w_free, w_do_spawn;
  logic [9:0]       w_h;
  logic [1:0]       w_bmp;

  assign bus.busy         = (r_state != StIdle);
  assign bus.active_count = r_active;

  always_comb begin
    w_state_next      = r_state;
    w_slot_next       = r_slot;
    w_free_idx_next   = r_free_idx;
    w_free_found_next = r_free_found;
    w_survivors_next  = r_survivors;
    w_active_next     = r_active;
    w_pending_next    = r_pending;
    w_frame_cnt_next  = r_frame_cnt;
    w_lfsr_next       = r_lfsr;
    w_do_spawn        = 1'b0;
    bus.rd_idx        = '0;
    bus.wr_en         = 1'b0;
    bus.wr_idx        = '0;
    bus.wr_data       = '0;
    bus.spawned       = 1'b0;
    bus.dropped       = 1'b0;

    w_exists = bus.rd_data[20];
    w_retire = w_exists && (bus.rd_data[19:10] >= ScreenH);
    w_free   = !w_exists || w_retire;
    // Fold out-of-range positions back once; bitmap 2'b11 is reserved for the player.
    w_h      = (r_lfsr[9:0] < HRange) ? r_lfsr[9:0] : (r_lfsr[9:0] - HRange);
    w_bmp    = (r_lfsr[11:10] == 2'b11) ? 2'b00 : r_lfsr[11:10];

    unique case (r_state)
      StIdle: begin
        if (bus.clear) begin
          w_state_next = StClear;
          w_slot_next  = FirstSlot;
        end else if (bus.frame_tick && bus.enable) begin
          w_state_next      = StScan;
          w_slot_next       = FirstSlot;
          w_free_found_next = 1'b0;
          w_free_idx_next   = '0;
          w_survivors_next  = '0;
          w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
          if (r_frame_cnt == FrameLast) begin
            w_frame_cnt_next = '0;
            w_pending_next   = 1'b1;
          end else begin
            w_frame_cnt_next = r_frame_cnt + FcW'(1);
          end
        end
      end
      StScan: begin
        bus.rd_idx = r_slot;
        if (w_retire) begin
          bus.wr_en       = 1'b1;
          bus.wr_idx      = r_slot;
          bus.wr_data     = bus.rd_data;
          bus.wr_data[20] = 1'b0;
        end
        if (w_free) begin
          if (!r_free_found) begin
            w_free_found_next = 1'b1;
            w_free_idx_next   = r_slot;
          end
        end else begin
          w_survivors_next = r_survivors + IDX_W'(1);
        end
        if (r_slot == LastSlot) w_state_next = StSpawn;
        else                    w_slot_next  = r_slot + IDX_W'(1);
      end
      StSpawn: begin
        if (r_pending) begin
          if (r_free_found) begin
            w_do_spawn  = 1'b1;
            bus.wr_en   = 1'b1;
            bus.wr_idx  = r_free_idx;
            bus.wr_data = {ObjSz, ObjSz, w_bmp, 1'b1, 10'd0, w_h};
            bus.spawned = 1'b1;
          end else begin
            bus.dropped = 1'b1;
          end
        end
        w_pending_next = 1'b0;
        w_active_next  = r_survivors + IDX_W'(w_do_spawn);
        w_state_next   = StIdle;
      end
      StClear: begin
        bus.rd_idx      = r_slot;
        bus.wr_en       = 1'b1;
        bus.wr_idx      = r_slot;
        bus.wr_data     = bus.rd_data;
        bus.wr_data[20] = 1'b0;
        if (r_slot == LastSlot) begin
          w_active_next    = '0;
          w_pending_next   = 1'b0;
          w_frame_cnt_next = '0;
          w_state_next     = StIdle;
        end else begin
          w_slot_next = r_slot + IDX_W'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_slot       <= '0;
      r_free_idx   <= '0;
      r_free_found <= 1'b0;
      r_survivors  <= '0;
      r_active     <= '0;
      r_pending    <= 1'b0;
      r_frame_cnt  <= '0;
      r_lfsr       <= LFSR_SEED;
    end else begin
      r_state      <= w_state_next;
      r_slot       <= w_slot_next;
      r_free_idx   <= w_free_idx_next;
      r_free_found <= w_free_found_next;
      r_survivors  <= w_survivors_next;
      r_active     <= w_active_next;
      r_pending    <= w_pending_next;
      r_frame_cnt  <= w_frame_cnt_next;
      r_lfsr       <= w_lfsr_next;
    end
  end
endmodule

// File: tb/tb_object_spawner.sv
// Directed bench for object_spawner: a period-1 instance for scan/spawn/clear behaviour
// and a period-60 instance for the spawn cadence.
module tb_object_spawner;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  object_spawner_if #(.IDX_W(4)) bus1 ();
  object_spawner_if #(.IDX_W(4)) bus60 ();

  object_spawner #(.SPAWN_PERIOD(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  object_spawner #(.SPAWN_PERIOD(60)) u_dut60 (
    .clk (clk),
    .rst (rst),
    .bus (bus60)
  );

  logic [34:0] bank1  [16];
  logic [34:0] bank60 [16];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [34:0] pl_data;

  assign bus1.rd_data  = bank1[bus1.rd_idx];
  assign bus60.rd_data = bank60[bus60.rd_idx];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) bank1[i] <= '0;
    end else begin
      if (bus1.wr_en) bank1[bus1.wr_idx] <= bus1.wr_data;
      if (pl_en) bank1[pl_idx] <= pl_data;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) bank60[i] <= '0;
    end else if (bus60.wr_en) begin
      bank60[bus60.wr_idx] <= bus60.wr_data;
    end
  end

  int          total = 0;
  int          bad = 0;
  logic [15:0] m_lfsr1;

  int          f_cyc, f_wcnt;
  logic        f_sp, f_dr;
  logic [3:0]  f_sidx, f_ridx;
  logic [34:0] f_sdata, f_rdata;
  logic        any_exists;
  int          p_cyc;
  logic        p_sp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [34:0] rec(input logic ex, input int unsigned v, input int unsigned h);
    return {6'd32, 6'd32, 2'b01, ex, v[9:0], h[9:0]};
  endfunction

  function automatic logic [34:0] spawn_rec(input logic [15:0] l);
    logic [9:0] h;
    logic [1:0] b;
    h = l[9:0];
    if (h >= 10'd768) h = h - 10'd768;
    b = l[11:10];
    if (b == 2'b11) b = 2'b00;
    return {6'd32, 6'd32, b, 1'b1, 10'd0, h};
  endfunction

  task automatic preload(input logic [3:0] idx, input logic [34:0] data);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One accepted tick on the period-1 instance, observing every busy cycle.
  task automatic frame1(output int cyc, output logic sp, output logic dr,
                        output logic [3:0] sidx, output logic [34:0] sdata, output int wcnt,
                        output logic [3:0] ridx, output logic [34:0] rdata);
    cyc = 0; sp = 1'b0; dr = 1'b0; sidx = '0; sdata = '0; wcnt = 0; ridx = '0; rdata = '0;
    @(negedge clk);
    bus1.frame_tick = 1'b1;
    bus1.enable     = 1'b1;
    m_lfsr1 = lfsr_step(m_lfsr1);
    @(negedge clk);
    bus1.frame_tick = 1'b0;
    while (bus1.busy && cyc < 40) begin
      cyc++;
      if (bus1.wr_en) begin
        wcnt++;
        if (bus1.spawned) begin
          sidx  = bus1.wr_idx;
          sdata = bus1.wr_data;
        end else begin
          ridx  = bus1.wr_idx;
          rdata = bus1.wr_data;
        end
      end
      if (bus1.spawned) sp = 1'b1;
      if (bus1.dropped) dr = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    bus1.frame_tick = 1'b0;  bus1.enable = 1'b1;  bus1.clear = 1'b0;
    bus60.frame_tick = 1'b0; bus60.enable = 1'b1; bus60.clear = 1'b0;
    m_lfsr1 = 16'hACE1;
    repeat (3) @(negedge clk);
    check("rst_busy", bus1.busy, 0);
    check("rst_wr_en", bus1.wr_en, 0);
    check("rst_rd_idx", bus1.rd_idx, 0);
    check("rst_wr_idx", bus1.wr_idx, 0);
    check("rst_wr_data", bus1.wr_data, 0);
    check("rst_active", bus1.active_count, 0);
    check("rst_pulses", {bus1.spawned, bus1.dropped}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Two live objects on screen; first spawn goes to slot 3 with hand-stepped LFSR 16'h59C3.
    preload(4'd1, rec(1'b1, 100, 50));
    preload(4'd2, rec(1'b1, 200, 60));
    frame1(f_cyc, f_sp, f_dr, f_sidx, f_sdata, f_wcnt, f_ridx, f_rdata);
    check("t1_busy_cycles", f_cyc, 16);
    check("t1_spawned", {f_sp, f_dr}, 2'b10);
    check("t1_spawn_idx", f_sidx, 3);
    check("t1_spawn_data", f_sdata, {6'd32, 6'd32, 2'b10, 1'b1, 10'd0, 10'd451});
    check("t1_write_count", f_wcnt, 1);
    check("t1_active", bus1.active_count, 3);
    check("t1_bank3", bank1[3], {6'd32, 6'd32, 2'b10, 1'b1, 10'd0, 10'd451});

    // Slot 2 leaves the screen (PosV 600) and is reused by the spawn; slot 1 at 599 stays.
    preload(4'd2, rec(1'b1, 600, 70));
    preload(4'd1, rec(1'b1, 599, 80));
    frame1(f_cyc, f_sp, f_dr, f_sidx, f_sdata, f_wcnt, f_ridx, f_rdata);
    check("t2_write_count", f_wcnt, 2);
    check("t2_retire_idx", f_ridx, 2);
    check("t2_retire_data", f_rdata, rec(1'b0, 600, 70));
    check("t2_spawn_idx", f_sidx, 2);
    check("t2_spawn_data", f_sdata, spawn_rec(m_lfsr1));
    check("t2_slot1_kept", bank1[1], rec(1'b1, 599, 80));
    check("t2_active", bus1.active_count, 3);

    // Full bank: spawn due but dropped.
    for (int i = 1; i < 16; i++) preload(4'(i), rec(1'b1, 100 + i, i));
    frame1(f_cyc, f_sp, f_dr, f_sidx, f_sdata, f_wcnt, f_ridx, f_rdata);
    check("t3_busy_cycles", f_cyc, 16);
    check("t3_pulses", {f_sp, f_dr}, 2'b01);
    check("t3_write_count", f_wcnt, 0);
    check("t3_active", bus1.active_count, 15);

    // Clear from IDLE sweeps slots 1..15 in order.
    @(negedge clk);
    bus1.clear = 1'b1;
    @(negedge clk);
    bus1.clear = 1'b0;
    for (int i = 1; i < 16; i++) begin
      check("clr_step", {bus1.wr_en, bus1.wr_idx, bus1.rd_idx, bus1.wr_data[20]},
            {1'b1, 4'(i), 4'(i), 1'b0});
      @(negedge clk);
    end
    check("clr_idle", bus1.busy, 0);
    check("clr_active", bus1.active_count, 0);
    check("clr_slot5", bank1[5], rec(1'b0, 105, 5));
    any_exists = 1'b0;
    for (int i = 1; i < 16; i++) any_exists = any_exists | bank1[i][20];
    check("clr_all_gone", any_exists, 0);

    // Clear together with a tick: CLEAR wins, so slot 1 is written at once.
    preload(4'd1, rec(1'b1, 100, 1));
    @(negedge clk);
    bus1.clear = 1'b1;
    bus1.frame_tick = 1'b1;
    @(negedge clk);
    bus1.clear = 1'b0;
    bus1.frame_tick = 1'b0;
    check("clr_tick_wins", {bus1.wr_en, bus1.wr_idx, bus1.wr_data[20]}, {1'b1, 4'd1, 1'b0});
    for (int i = 0; i < 20 && bus1.busy; i++) @(negedge clk);
    check("clr_tick_idle", bus1.busy, 0);

    // Tick with enable low is ignored.
    @(negedge clk);
    bus1.frame_tick = 1'b1;
    bus1.enable = 1'b0;
    @(negedge clk);
    bus1.frame_tick = 1'b0;
    bus1.enable = 1'b1;
    check("en_low_ignored", bus1.busy, 0);

    // Period 60: enable-low ticks and ticks during busy must not advance the cadence.
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      bus60.frame_tick = 1'b1;
      bus60.enable = 1'b0;
      @(negedge clk);
      bus60.frame_tick = 1'b0;
      bus60.enable = 1'b1;
      @(negedge clk);
      bus60.frame_tick = 1'b1;
      @(negedge clk);
      bus60.frame_tick = 1'b0;
      p_cyc = 0;
      p_sp = 1'b0;
      while (bus60.busy && p_cyc < 40) begin
        bus60.frame_tick = (p_cyc == 4);
        if (bus60.spawned) p_sp = 1'b1;
        p_cyc++;
        @(negedge clk);
      end
      bus60.frame_tick = 1'b0;
      check("p60_busy_cycles", p_cyc, 16);
      check("p60_spawn", p_sp, (n == 60));
      check("p60_active", bus60.active_count, (n == 60) ? 1 : 0);
    end

    // 1000 spawns into slot 1, compared against the LFSR model.
    for (int n = 0; n < 1000; n++) begin
      frame1(f_cyc, f_sp, f_dr, f_sidx, f_sdata, f_wcnt, f_ridx, f_rdata);
      check("sw_spawned", {f_sp, f_sidx}, {1'b1, 4'd1});
      check("sw_data", f_sdata, spawn_rec(m_lfsr1));
      check("sw_posh_range", (f_sdata[9:0] <= 10'd767), 1);
      check("sw_bmp_not_player", (f_sdata[22:21] != 2'b11), 1);
      preload(4'd1, '0);
    end

    // Async reset mid-scan forces every output back immediately.
    @(negedge clk);
    bus1.frame_tick = 1'b1;
    @(negedge clk);
    bus1.frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_scan_busy", bus1.busy, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", bus1.busy, 0);
    check("rst_mid_rd_idx", bus1.rd_idx, 0);
    check("rst_mid_wr", {bus1.wr_en, bus1.wr_idx}, 0);
    check("rst_mid_wr_data", bus1.wr_data, 0);
    check("rst_mid_active", bus1.active_count, 0);
    check("rst_mid_pulses", {bus1.spawned, bus1.dropped}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
